// File: rtl/dcache_wt_pkg.sv
// Shared types and default geometry for the write-through data cache.
package dcache_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int INDEX_BITS_DEF  = 3;
  localparam int MEM_LATENCY_DEF = 4;

  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int TAG_BITS = XLEN_DEF - INDEX_BITS_DEF - 2;
  localparam int CNT_BITS = cnt_width(MEM_LATENCY_DEF);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, WR_DONE} state_e;

  // Four byte lanes, lane 0 in the least significant byte.
  typedef logic [3:0][7:0] word_t;

endpackage

// File: rtl/dcache_wt_if.sv
// CPU-side and memory-side signals of the data cache bundled into one interface.
interface dcache_if
  import dcache_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            halted;
  logic            cpu_req;
  logic            cpu_we;
  logic [XLEN-1:0] cpu_addr;
  word_t           cpu_wdata;
  word_t           cpu_rdata;
  logic            stall;
  logic [XLEN-1:0] mem_addr;
  word_t           mem_wdata;
  word_t           mem_rdata;
  logic            mem_we;

  modport master (
    output halted, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, stall, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  halted, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, stall, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dcache_wt_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_W      = TAG_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output word_t                 rd_data_o,
  input  logic                  fill_en_i,
  input  logic                  upd_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  word_t                 wr_data_i
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  word_t            data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) tag_q[wr_idx_i] <= wr_tag_i;
    if (fill_en_i || upd_en_i) data_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with fixed-latency memory.
// Optional load hit/miss counters when DCACHE_STATS_EN is defined.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int INDEX_BITS  = INDEX_BITS_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);
  localparam int TAG_W = XLEN - INDEX_BITS - 2;
  localparam int CNT_W = cnt_width(MEM_LATENCY);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  addr_q;
  word_t            wdata_q;
  logic             mem_we_q;

  logic [XLEN-1:0]       cpu_waddr;
  logic [INDEX_BITS-1:0] cpu_idx, lat_idx;
  logic [TAG_W-1:0]      cpu_tag, lat_tag, line_tag;
  logic                  line_valid;
  word_t                 line_data;
  logic                  req_go, hit, rd_hit, fill_en, upd_en;

  assign cpu_waddr = bus.cpu_addr & ~XLEN'(3);
  assign cpu_idx   = cpu_waddr[INDEX_BITS+1:2];
  assign cpu_tag   = cpu_waddr[XLEN-1:INDEX_BITS+2];
  assign lat_idx   = addr_q[INDEX_BITS+1:2];
  assign lat_tag   = addr_q[XLEN-1:INDEX_BITS+2];

  assign req_go  = bus.cpu_req && !bus.halted;
  assign hit     = line_valid && (line_tag == cpu_tag);
  assign rd_hit  = (state_q == IDLE) && req_go && !bus.cpu_we && hit;
  assign fill_en = (state_q == RD_WAIT) && (cnt_q == '0);
  assign upd_en  = (state_q == IDLE) && req_go && bus.cpu_we && hit;

  dcache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk_i      (clk_i),
    .rst_b_i    (rst_b_i),
    .rd_idx_i   (cpu_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .fill_en_i  (fill_en),
    .upd_en_i   (upd_en),
    .wr_idx_i   (fill_en ? lat_idx : cpu_idx),
    .wr_tag_i   (lat_tag),
    .wr_data_i  (fill_en ? bus.mem_rdata : bus.cpu_wdata)
  );

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        fill_q;

  // fill_q marks the retry cycle right after a fill so it is not counted as a hit.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      fill_q     <= 1'b0;
    end else begin
      fill_q <= fill_en;
      if (rd_hit && !fill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && req_go && !bus.cpu_we && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_go && bus.cpu_we) begin
            addr_q   <= cpu_waddr;
            wdata_q  <= bus.cpu_wdata;
            cnt_q    <= CNT_W'(MEM_LATENCY - 1);
            mem_we_q <= 1'b1;
            state_q  <= WR_WAIT;
          end else if (req_go && !hit) begin
            addr_q  <= cpu_waddr;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        WR_WAIT: begin
          if (cnt_q == '0) begin
            mem_we_q <= 1'b0;
            state_q  <= WR_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall = 1'b0;
    case (state_q)
      IDLE:             bus.stall = req_go && (bus.cpu_we || !hit);
      RD_WAIT, WR_WAIT: bus.stall = 1'b1;
      default:          bus.stall = 1'b0;
    endcase
  end

  assign bus.mem_addr  = (state_q == IDLE) ? cpu_waddr : addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_rdata = rd_hit ? line_data : '0;

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: vector table, scoreboard queue, and corner-case sequences.
module tb_dcache_wt;
  import dcache_pkg::*;

  localparam int MISS_STALLS = MEM_LATENCY_DEF + 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.XLEN(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_wt dut (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .bus     (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
    int          we_cycles;
    logic [31:0] maddr;
    logic        is_load;
    string       name;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input int exp_stalls, input string nm);
    exp_t e, got;
    int stalls = 0;
    int wec = 0;
    bit done = 0;
    logic [31:0] rd = '0;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    e.rdata     = exp_rd;
    e.stalls    = exp_stalls;
    e.we_cycles = we ? MEM_LATENCY_DEF : 0;
    e.maddr     = addr & 32'hFFFF_FFFC;
    e.is_load   = !we;
    e.name      = nm;
    sbq.push_back(e);
    #1;
    got.maddr = bus.mem_addr;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (bus.mem_we) wec++;
      if (bus.stall) stalls++;
      else begin
        done = 1;
        rd = bus.cpu_rdata;
      end
    end
    e = sbq.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=stall_stuck required=stall_release", e.name);
    end
    chk({e.name, "_stalls"}, stalls, e.stalls);
    chk({e.name, "_mem_addr"}, got.maddr, e.maddr);
    chk({e.name, "_we_cycles"}, wec, e.we_cycles);
    if (e.is_load) chk({e.name, "_rdata"}, rd, e.rdata);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    #1;
    chk({e.name, "_idle_stall"}, bus.stall, 1'b0);
  endtask

  initial begin
    bus.halted    = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'hDEAD_BEEF;
    mem[24] = 32'hCAFE_F00D;
    mem[32] = 32'h0BAD_F00D;

    vecs[0]  = '{1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, MISS_STALLS, "ld40_miss"};
    vecs[1]  = '{1'b0, 32'h43, 32'h0,         32'hDEAD_BEEF, 0,           "ld40_hit"};
    vecs[2]  = '{1'b1, 32'h40, 32'h1122_3344, 32'h0,         MISS_STALLS, "st40_hit"};
    vecs[3]  = '{1'b0, 32'h40, 32'h0,         32'h1122_3344, 0,           "ld40_after_st"};
    vecs[4]  = '{1'b1, 32'h80, 32'hA5A5_5A5A, 32'h0,         MISS_STALLS, "st80_miss"};
    vecs[5]  = '{1'b0, 32'h80, 32'h0,         32'hA5A5_5A5A, MISS_STALLS, "ld80_noalloc"};
    vecs[6]  = '{1'b0, 32'h60, 32'h0,         32'hCAFE_F00D, MISS_STALLS, "ld60_alias"};
    vecs[7]  = '{1'b0, 32'h40, 32'h0,         32'h1122_3344, MISS_STALLS, "ld40_evicted"};
    vecs[8]  = '{1'b0, 32'h42, 32'h0,         32'h1122_3344, 0,           "ld40_rehit"};
    vecs[9]  = '{1'b1, 32'h44, 32'h5566_7788, 32'h0,         MISS_STALLS, "st44_miss"};
    vecs[10] = '{1'b0, 32'h44, 32'h0,         32'h5566_7788, MISS_STALLS, "ld44_miss"};
    vecs[11] = '{1'b0, 32'h44, 32'h0,         32'h5566_7788, 0,           "ld44_hit"};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", bus.stall, 1'b0);
    chk("reset_mem_we", bus.mem_we, 1'b0);
    rst_b = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].stalls, vecs[i].name);
`ifdef DCACHE_STATS_EN
      if (i == 1) begin
        chk("stats_hit", hit_count, 32'd1);
        chk("stats_miss", miss_count, 32'd1);
      end
`endif
    end

    // Reset during the second WR_WAIT cycle aborts the store.
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h60;
    bus.cpu_wdata = 32'h0000_0099;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid_we_before", bus.mem_we, 1'b1);
    rst_b = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_mem_we", bus.mem_we, 1'b0);
    chk("rst_mid_stall", bus.stall, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("rst_stats_hit", hit_count, 32'd0);
    chk("rst_stats_miss", miss_count, 32'd0);
`endif
    rst_b = 1'b1;
    run_access(1'b0, 32'h40, 32'h0, 32'h1122_3344, MISS_STALLS, "ld40_after_rst");

    // Halted: requests ignored, no stall, no memory write.
    @(negedge clk);
    bus.halted    = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h40;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("halted_stall", bus.stall, 1'b0);
      chk("halted_mem_we", bus.mem_we, 1'b0);
      @(negedge clk);
    end
    bus.halted  = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    run_access(1'b0, 32'h40, 32'h0, 32'h1122_3344, 0, "ld40_after_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
